rename_recovery_ctrl: RTL and testbench
=======================================

# rename_recovery_ctrl

Sequencer that rebuilds rename state after a pipeline flush (branch mispredict or exception). It copies the committed RRAT mapping into the FRAT one architectural register per cycle. It then rebuilds the physical-register free list by scanning for physical tags not referenced by the RRAT, and clears all busy bits. It sits beside the Rename stage between ROB/RRAT and the FRAT/free-list queue, and holds rename stalled until recovery completes.

## Interface
Parameters:
- ARCH_REGS, 32, architectural register count
- PHYS_REGS, 64, physical register count
- IDX_W, 5, architectural index width
- TAG_W, 6, physical tag width

Ports:
- CLK  in  1  single clock; all state updates on rising edge
- RESET  in  1  synchronous, active-high reset
- flush_req  in  1  flush request from ROB; sampled every rising edge
- rrat_rd_idx  out  IDX_W  RRAT read address
- rrat_rd_map  in  TAG_W  combinational RRAT read data for rrat_rd_idx
- frat_wr_en  out  1  FRAT write strobe
- frat_wr_idx  out  IDX_W  FRAT write address
- frat_wr_map  out  TAG_W  FRAT write data
- fl_clear  out  1  empties the free-list queue (pointers to zero)
- fl_enque  out  1  free-list push strobe
- fl_enque_data  out  TAG_W  tag pushed
- busy_clear_all  out  1  clears all 64 busy bits
- halt_rename  out  1  stalls Rename and the rename queue
- recovery_done  out  1  one-cycle completion pulse
- map_dup_err  out  1  sticky error: RRAT maps two arch regs to the same tag

## Operation
- States: IDLE, CLEAR, COPY, SCAN, DONE. Internal state: counter cnt (TAG_W+1 bits) and used[PHYS_REGS-1:0].
- IDLE: the only activity is waiting. flush_req=1 moves to CLEAR.
- CLEAR, 1 cycle:
  - Drives fl_clear=1 and busy_clear_all=1.
  - Sets used<=0 and cnt<=0, then moves to COPY.
- COPY, ARCH_REGS cycles:
  - Drives rrat_rd_idx=cnt[IDX_W-1:0].
  - At each edge, registers frat_wr_en<=1, frat_wr_idx<=cnt, frat_wr_map<=rrat_rd_map.
  - At the same edge, sets used[rrat_rd_map]<=1. If that bit is already 1, sets map_dup_err<=1.
  - After cnt=ARCH_REGS-1: cnt<=0, move to SCAN.
- SCAN, PHYS_REGS cycles:
  - At each edge, registers fl_enque<=~used[cnt] and fl_enque_data<=cnt[TAG_W-1:0].
  - After cnt=PHYS_REGS-1, move to DONE.
  - Pushes are emitted in ascending tag order.
- DONE, 1 cycle: recovery_done=1, then return to IDLE.
- Outputs by state:
  - halt_rename=1 in every state except IDLE.
  - fl_clear, busy_clear_all and recovery_done are decoded from state.
  - frat_wr_* and fl_enque* are registered, so they lag the state that generates them by one cycle.
- Restart rule: flush_req=1 in any non-IDLE state moves to CLEAR on the next edge.
  - Restart cancels the pending registered frat_wr_en/fl_enque.
  - A flush_req held high keeps the block in CLEAR.
- map_dup_err clears only on RESET or on entry to CLEAR.
- With a legal RRAT (distinct tags), SCAN produces exactly PHYS_REGS-ARCH_REGS pushes.

## Timing
- Cycle 0 is the edge at which flush_req=1 is sampled in IDLE.
- Cycle 1: CLEAR. fl_clear, busy_clear_all and halt_rename are high.
- Cycles 2..33: COPY. rrat_rd_idx = 0..31.
- Cycles 3..34: frat_wr_en=1, with frat_wr_idx = 0..31 respectively.
- Cycles 34..97: SCAN, cnt = 0..63.
- Cycles 35..98: fl_enque reflects tags 0..63.
- Cycle 98: DONE, recovery_done=1, halt_rename=1.
- Cycle 99: IDLE, halt_rename=0. Total 98 halted cycles.
- Reset values, all outputs: 0. This covers rrat_rd_idx, frat_wr_*, fl_*, busy_clear_all, halt_rename, recovery_done and map_dup_err.
- Reset internal values: state=IDLE, cnt=0, used=0.
- RESET dominates flush_req. RESET mid-recovery returns to IDLE next edge with no further writes or pushes.
- No backpressure from FRAT or free list; each accepts one operation per cycle unconditionally.

## Test plan
- Identity map: RRAT[i]=i, flush_req pulse at cycle 0.
  - FRAT writes i→i on cycles 3..34.
  - fl_enque on cycles 67..98 with data 32..63 ascending.
  - recovery_done at cycle 98; map_dup_err=0.
- Permuted map: RRAT[i]=63-i.
  - FRAT writes i→63-i.
  - Pushed tags are 0..31 ascending; exactly 32 pushes.
- Duplicate map: RRAT[5]=RRAT[6]=40, others identity.
  - map_dup_err rises after the cycle-8 edge and stays high.
  - 33 pushes are emitted, including tags 5, 6 and 32..39, 41..63. Tag 40 is not pushed.
- Flush at SCAN cycle 50:
  - Next cycle is CLEAR with fl_clear=1.
  - The sequence restarts; recovery_done comes 98 cycles after the second flush.
  - No recovery_done is produced from the aborted run.
- RESET=1 during COPY cycle 10:
  - All outputs are 0 next cycle and state is IDLE.
  - A subsequent flush_req performs a full recovery.
- flush_req held high 5 cycles from IDLE:
  - halt_rename stays high and the block remains in CLEAR for 5 cycles.
  - COPY starts the cycle after flush_req falls.

Source files
------------

// File: rtl/rename_recovery_ctrl.sv
// Flush recovery sequencer: copies the committed RRAT into the FRAT, rebuilds the
// free list from tags the RRAT does not reference, and stalls rename meanwhile.
module rename_recovery_ctrl #(
    parameter int ARCH_REGS = 32,
    parameter int PHYS_REGS = 64,
    parameter int IDX_W     = 5,
    parameter int TAG_W     = 6
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             flush_req,
    output logic [IDX_W-1:0] rrat_rd_idx,
    input  logic [TAG_W-1:0] rrat_rd_map,
    output logic             frat_wr_en,
    output logic [IDX_W-1:0] frat_wr_idx,
    output logic [TAG_W-1:0] frat_wr_map,
    output logic             fl_clear,
    output logic             fl_enque,
    output logic [TAG_W-1:0] fl_enque_data,
    output logic             busy_clear_all,
    output logic             halt_rename,
    output logic             recovery_done,
    output logic             map_dup_err
);

    localparam int CNT_W = TAG_W + 1;
    localparam logic [CNT_W-1:0] LAST_ARCH = CNT_W'(ARCH_REGS - 1);
    localparam logic [CNT_W-1:0] LAST_PHYS = CNT_W'(PHYS_REGS - 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_COPY  = 3'd2,
        ST_SCAN  = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

    state_e                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [PHYS_REGS-1:0]   used_q, used_d;
    logic                   dup_q, dup_d;
    logic                   frat_en_q, frat_en_d;
    logic [IDX_W-1:0]       frat_idx_q, frat_idx_d;
    logic [TAG_W-1:0]       frat_map_q, frat_map_d;
    logic                   enq_q, enq_d;
    logic [TAG_W-1:0]       enq_data_q, enq_data_d;

    // Next-state, counter, used-set and registered-strobe computation
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        used_d     = used_q;
        dup_d      = dup_q;
        frat_en_d  = 1'b0;
        frat_idx_d = '0;
        frat_map_d = '0;
        enq_d      = 1'b0;
        enq_data_d = '0;
        case (state_q)
            ST_IDLE: begin
                if (flush_req) begin
                    state_d = ST_CLEAR;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_CLEAR: begin
                used_d = '0;
                cnt_d  = '0;
                if (flush_req) begin
                    state_d = ST_CLEAR;
                end else begin
                    state_d = ST_COPY;
                end
            end
            ST_COPY: begin
                if (flush_req) begin
                    state_d = ST_CLEAR;
                end else begin
                    frat_en_d   = 1'b1;
                    frat_idx_d  = cnt_q[IDX_W-1:0];
                    frat_map_d  = rrat_rd_map;
                    used_d[rrat_rd_map] = 1'b1;
                    // A tag already claimed by a lower arch reg means the RRAT is corrupt
                    if (used_q[rrat_rd_map]) begin
                        dup_d = 1'b1;
                    end else begin
                        dup_d = dup_q;
                    end
                    if (cnt_q == LAST_ARCH) begin
                        cnt_d   = '0;
                        state_d = ST_SCAN;
                    end else begin
                        cnt_d   = cnt_q + CNT_W'(1);
                        state_d = ST_COPY;
                    end
                end
            end
            ST_SCAN: begin
                if (flush_req) begin
                    state_d = ST_CLEAR;
                end else begin
                    enq_d      = ~used_q[cnt_q[TAG_W-1:0]];
                    enq_data_d = cnt_q[TAG_W-1:0];
                    if (cnt_q == LAST_PHYS) begin
                        cnt_d   = '0;
                        state_d = ST_DONE;
                    end else begin
                        cnt_d   = cnt_q + CNT_W'(1);
                        state_d = ST_SCAN;
                    end
                end
            end
            ST_DONE: begin
                if (flush_req) begin
                    state_d = ST_CLEAR;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        if (state_d == ST_CLEAR) begin
            dup_d = 1'b0;
        end else begin
            dup_d = dup_d;
        end
    end

    // State and registered-output update with synchronous reset
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            used_q     <= '0;
            dup_q      <= 1'b0;
            frat_en_q  <= 1'b0;
            frat_idx_q <= '0;
            frat_map_q <= '0;
            enq_q      <= 1'b0;
            enq_data_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            used_q     <= used_d;
            dup_q      <= dup_d;
            frat_en_q  <= frat_en_d;
            frat_idx_q <= frat_idx_d;
            frat_map_q <= frat_map_d;
            enq_q      <= enq_d;
            enq_data_q <= enq_data_d;
        end
    end

    // State-decoded control outputs
    always_comb begin
        rrat_rd_idx    = '0;
        fl_clear       = 1'b0;
        busy_clear_all = 1'b0;
        recovery_done  = 1'b0;
        halt_rename    = 1'b1;
        case (state_q)
            ST_IDLE: begin
                halt_rename = 1'b0;
            end
            ST_CLEAR: begin
                fl_clear       = 1'b1;
                busy_clear_all = 1'b1;
            end
            ST_COPY: begin
                rrat_rd_idx = cnt_q[IDX_W-1:0];
            end
            ST_SCAN: begin
                halt_rename = 1'b1;
            end
            ST_DONE: begin
                recovery_done = 1'b1;
            end
            default: begin
                halt_rename = 1'b1;
            end
        endcase
    end

    assign frat_wr_en    = frat_en_q;
    assign frat_wr_idx   = frat_idx_q;
    assign frat_wr_map   = frat_map_q;
    assign fl_enque      = enq_q;
    assign fl_enque_data = enq_data_q;
    assign map_dup_err   = dup_q;

endmodule

// File: tb/tb_rename_recovery_ctrl.sv
// Bench for rename_recovery_ctrl: timeline model (cycles since flush) checked every
// cycle, plus per-scenario literal expectations on push counts, sets and latencies.
module tb_rename_recovery_ctrl;
    localparam int ARCH   = 32;
    localparam int PHYS   = 64;
    localparam int T_DONE = ARCH + PHYS + 2;

    logic       CLK, RESET, flush_req;
    logic [4:0] rrat_rd_idx;
    logic [5:0] rrat_rd_map;
    logic       frat_wr_en;
    logic [4:0] frat_wr_idx;
    logic [5:0] frat_wr_map;
    logic       fl_clear, fl_enque, busy_clear_all, halt_rename, recovery_done, map_dup_err;
    logic [5:0] fl_enque_data;

    logic [5:0] rrat [ARCH];
    assign rrat_rd_map = rrat[rrat_rd_idx];

    rename_recovery_ctrl dut (
        .CLK(CLK), .RESET(RESET), .flush_req(flush_req),
        .rrat_rd_idx(rrat_rd_idx), .rrat_rd_map(rrat_rd_map),
        .frat_wr_en(frat_wr_en), .frat_wr_idx(frat_wr_idx), .frat_wr_map(frat_wr_map),
        .fl_clear(fl_clear), .fl_enque(fl_enque), .fl_enque_data(fl_enque_data),
        .busy_clear_all(busy_clear_all), .halt_rename(halt_rename),
        .recovery_done(recovery_done), .map_dup_err(map_dup_err)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int n_pass = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit in_rrat(input int tag);
        for (int j = 0; j < ARCH; j++) if (int'(rrat[j]) == tag) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit seen_before(input int i);
        for (int j = 0; j < i; j++) if (rrat[j] == rrat[i]) return 1'b1;
        return 1'b0;
    endfunction

    // Model: m_t = cycles since recovery began (1 = CLEAR, T_DONE = DONE, 0 = idle)
    int m_t = 0;
    bit m_dup = 1'b0;
    always @(posedge CLK) begin
        if (RESET) begin
            m_t <= 0;
            m_dup <= 1'b0;
        end else if (flush_req) begin
            m_t <= 1;
            m_dup <= 1'b0;
        end else if (m_t == 0 || m_t == T_DONE) begin
            m_t <= 0;
        end else begin
            m_t <= m_t + 1;
            if (m_t + 1 >= 3 && m_t + 1 <= ARCH + 2 && seen_before(m_t - 2)) m_dup <= 1'b1;
        end
    end

    // Per-cycle comparison against the model
    always @(posedge CLK) begin
        int t;
        bit scan;
        #3;
        t = m_t;
        scan = (t >= ARCH + 3) && (t <= T_DONE);
        chk("halt_rename", halt_rename, t != 0);
        chk("fl_clear", fl_clear, t == 1);
        chk("busy_clear_all", busy_clear_all, t == 1);
        chk("recovery_done", recovery_done, t == T_DONE);
        chk("rrat_rd_idx", rrat_rd_idx, (t >= 2 && t <= ARCH + 1) ? t - 2 : 0);
        chk("frat_wr_en", frat_wr_en, t >= 3 && t <= ARCH + 2);
        if (t >= 3 && t <= ARCH + 2) begin
            chk("frat_wr_idx", frat_wr_idx, t - 3);
            chk("frat_wr_map", frat_wr_map, rrat[t-3]);
        end
        chk("fl_enque", fl_enque, scan && !in_rrat(t - ARCH - 3));
        if (scan) chk("fl_enque_data", fl_enque_data, t - ARCH - 3);
        chk("map_dup_err", map_dup_err, m_dup);
    end

    int pushes, done_cyc, done_cnt, halt_cnt, clear_cnt, first_clear;
    int first_wr, first_push, last_push, dup_first;
    logic [63:0] pushed_tags;

    // Runs one recovery, observing cycle c at the negedge before edge c.
    task automatic recover(input int hold, input int abort_at, input int reset_at, input bit preset);
        pushes = 0; done_cyc = 0; done_cnt = 0; halt_cnt = 0; clear_cnt = 0; first_clear = 0;
        first_wr = 0; first_push = 0; last_push = 0; dup_first = 0; pushed_tags = '0;
        if (!preset) begin
            @(negedge CLK);
            flush_req = 1'b1;
        end
        for (int c = 1; c <= 140; c++) begin
            @(negedge CLK);
            if (fl_enque) begin
                pushes++;
                pushed_tags[fl_enque_data] = 1'b1;
                if (first_push == 0) first_push = c;
                last_push = c;
            end
            if (frat_wr_en && first_wr == 0) first_wr = c;
            if (halt_rename) halt_cnt++;
            if (fl_clear) begin
                clear_cnt++;
                if (first_clear == 0) first_clear = c;
            end
            if (map_dup_err && dup_first == 0) dup_first = c;
            if (recovery_done) begin
                done_cnt++;
                if (done_cyc == 0) done_cyc = c;
            end
            if (c == abort_at) begin
                flush_req = 1'b1;
                return;
            end
            if (c == reset_at) begin
                RESET = 1'b1;
                flush_req = 1'b0;
                return;
            end
            flush_req = (c < hold);
            if (done_cyc > 0 && c > done_cyc) break;
        end
    endtask

    task automatic set_identity();
        for (int i = 0; i < ARCH; i++) rrat[i] = 6'(i);
    endtask

    initial begin
        RESET = 1'b1;
        flush_req = 1'b0;
        set_identity();
        repeat (3) @(negedge CLK);
        RESET = 1'b0;
        chk("reset_halt", halt_rename, 1'b0);
        chk("reset_dup", map_dup_err, 1'b0);
        chk("reset_rd_idx", rrat_rd_idx, 5'd0);

        // Identity map
        recover(1, 0, 0, 1'b0);
        chk("id_done_cyc", done_cyc, 98);
        chk("id_done_cnt", done_cnt, 1);
        chk("id_pushes", pushes, 32);
        chk("id_first_push", first_push, 67);
        chk("id_last_push", last_push, 98);
        chk("id_first_wr", first_wr, 3);
        chk("id_halt_cycles", halt_cnt, 98);
        chk("id_tags", pushed_tags, 64'hFFFF_FFFF_0000_0000);
        chk("id_dup", map_dup_err, 1'b0);

        // Reversed map
        for (int i = 0; i < ARCH; i++) rrat[i] = 6'(63 - i);
        recover(1, 0, 0, 1'b0);
        chk("perm_pushes", pushes, 32);
        chk("perm_tags", pushed_tags, 64'h0000_0000_FFFF_FFFF);
        chk("perm_done_cyc", done_cyc, 98);

        // Duplicate tag 40 at arch regs 5 and 6
        set_identity();
        rrat[5] = 6'd40;
        rrat[6] = 6'd40;
        recover(1, 0, 0, 1'b0);
        chk("dup_first_cyc", dup_first, 9);
        chk("dup_pushes", pushes, 33);
        chk("dup_tag40", pushed_tags[40], 1'b0);
        chk("dup_tags", pushed_tags, 64'hFFFF_FEFF_0000_0060);
        chk("dup_sticky", map_dup_err, 1'b1);

        // Restart from SCAN at cycle 50; also clears the sticky error
        set_identity();
        recover(1, 50, 0, 1'b0);
        chk("abort_no_done", done_cnt, 0);
        recover(1, 0, 0, 1'b1);
        chk("abort_first_clear", first_clear, 1);
        chk("abort_done_cyc", done_cyc, 98);
        chk("abort_done_cnt", done_cnt, 1);
        chk("abort_dup_clr", map_dup_err, 1'b0);

        // Reset during COPY cycle 10
        recover(1, 0, 10, 1'b0);
        @(negedge CLK);
        RESET = 1'b0;
        chk("rst_halt", halt_rename, 1'b0);
        chk("rst_wr_en", frat_wr_en, 1'b0);
        chk("rst_rd_idx", rrat_rd_idx, 5'd0);
        recover(1, 0, 0, 1'b0);
        chk("rst_done_cyc", done_cyc, 98);
        chk("rst_pushes", pushes, 32);

        // flush_req held for 5 edges
        recover(5, 0, 0, 1'b0);
        chk("hold_clear_cnt", clear_cnt, 5);
        chk("hold_first_wr", first_wr, 7);
        chk("hold_done_cyc", done_cyc, 102);
        chk("hold_halt_cycles", halt_cnt, 102);

        repeat (2) @(negedge CLK);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
